// File: rtl/dsp_route_pkg.sv
// rtl/dsp_route_pkg.sv - register offsets and helper functions for the route/sum matrix
package dsp_route_pkg;

    localparam logic [11:0] SEL_BASE  = 12'h000;
    localparam logic [11:0] MASK_BASE = 12'h100;
    localparam logic [11:0] COMMIT    = 12'h200;
    localparam logic [11:0] STATUS    = 12'h204;
    localparam logic [11:0] OVF_BASE  = 12'h208;

    localparam int SHIFT_LSB = 8;
    localparam int SHIFT_W   = 3;
    localparam int PEND_BIT  = 16;

    // All-ones select code; always >= N_SRC because SELW reserves room for it.
    function automatic int unsigned sel_none(input int unsigned selw);
        return (32'd1 << selw) - 32'd1;
    endfunction

    function automatic longint sat_max(input int unsigned dw);
        return (longint'(1) << (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/dsp_route_addtree.sv
// rtl/dsp_route_addtree.sv - masked, pipelined adder tree with output saturation
// Optional per-source attenuation when DSP_ROUTE_SHIFT_EN is defined.
module dsp_route_addtree
    import dsp_route_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter int DW    = 14,
    parameter int SELW  = $clog2(N_SRC + 1)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [N_SRC*DW-1:0] dir_dat_i,
    input  logic [N_SRC-1:0]    mask_i,
`ifdef DSP_ROUTE_SHIFT_EN
    input  logic [N_SRC*3-1:0]  shift_i,
`endif
    output logic [DW-1:0]       sum_o,
    output logic                sat_o
);

    localparam int LV = $clog2(N_SRC);
    localparam int NP = 1 << LV;
    localparam int AW = DW + SELW;
    localparam int NN = 2 * NP - 1;

    localparam logic signed [AW-1:0] S_MAX = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] S_MIN = AW'(sat_min(DW));

    // Heap layout: node i sums children 2i+1 and 2i+2, leaves start at NP-1.
    logic signed [AW-1:0] node_q [NN];
    logic signed [AW-1:0] leaf_d [NP];

    always_comb begin
        for (int j = 0; j < NP; j++) begin
            leaf_d[j] = '0;
        end
        for (int j = 0; j < N_SRC; j++) begin
            if (mask_i[j]) begin
`ifdef DSP_ROUTE_SHIFT_EN
                leaf_d[j] = AW'($signed(dir_dat_i[j*DW +: DW]) >>> shift_i[j*3 +: 3]);
`else
                leaf_d[j] = AW'($signed(dir_dat_i[j*DW +: DW]));
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NN; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NP; j++) begin
                node_q[NP-1+j] <= leaf_d[j];
            end
            for (int i = 0; i < NP - 1; i++) begin
                node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
            end
        end
    end

    always_comb begin
        sat_o = 1'b0;
        sum_o = node_q[0][DW-1:0];
        if (node_q[0] > S_MAX) begin
            sat_o = 1'b1;
            sum_o = S_MAX[DW-1:0];
        end else if (node_q[0] < S_MIN) begin
            sat_o = 1'b1;
            sum_o = S_MIN[DW-1:0];
        end
    end

endmodule

// File: rtl/dsp_route_sum_matrix.sv
// rtl/dsp_route_sum_matrix.sv - routing crossbar and DAC summing matrix with atomic commit
// Optional per-source attenuation when DSP_ROUTE_SHIFT_EN is defined.
module dsp_route_sum_matrix
    import dsp_route_pkg::*;
#(
    parameter int N_SRC  = 16,
    parameter int N_SINK = 12,
    parameter int N_OUT  = 2,
    parameter int DW     = 14,
    parameter int SELW   = $clog2(N_SRC + 1),
    parameter int CNTW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [N_SRC*DW-1:0]  src_dat_i,
    input  logic [N_SRC*DW-1:0]  dir_dat_i,
    output logic [N_SINK*DW-1:0] sink_dat_o,
    output logic [N_OUT*DW-1:0]  out_dat_o,
    output logic [N_OUT-1:0]     out_sat_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_ack,
    output logic                 sys_err
);

    localparam logic [SELW-1:0] NONE = SELW'(sel_none(SELW));

    logic [SELW-1:0]  sel_sh_q   [N_SINK];
    logic [SELW-1:0]  sel_act_q  [N_SINK];
    logic [N_OUT-1:0] mask_sh_q  [N_SRC];
    logic [N_OUT-1:0] mask_act_q [N_SRC];
`ifdef DSP_ROUTE_SHIFT_EN
    logic [2:0]       shift_sh_q  [N_SRC];
    logic [2:0]       shift_act_q [N_SRC];
    logic [N_SRC*3-1:0] shift_flat;
`endif
    logic             pending_q;
    logic [N_OUT-1:0] sticky_q, sticky_d, clr_sticky;
    logic [CNTW-1:0]  ovf_q [N_OUT];
    logic [CNTW-1:0]  ovf_d [N_OUT];
    logic [N_SINK*DW-1:0] sink_q, sink_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_q, err_q;

    logic [11:0] addr, off_sel, off_mask, off_ovf;
    logic        hit_sel, hit_mask, hit_ovf, is_commit, is_status, bad;
    logic        unused_bits;

    assign unused_bits = ^{sys_addr[31:12], sys_wdata};

    assign addr      = sys_addr[11:0];
    assign off_sel   = addr - SEL_BASE;
    assign off_mask  = addr - MASK_BASE;
    assign off_ovf   = addr - OVF_BASE;
    assign hit_sel   = (addr[1:0] == 2'b00) && (off_sel  < 12'(4 * N_SINK));
    assign hit_mask  = (addr[1:0] == 2'b00) && (off_mask < 12'(4 * N_SRC));
    assign hit_ovf   = (addr[1:0] == 2'b00) && (off_ovf  < 12'(4 * N_OUT));
    assign is_commit = (addr == COMMIT);
    assign is_status = (addr == STATUS);
    assign bad       = !(hit_sel || hit_mask || hit_ovf || is_commit || is_status);

    always_comb begin
        rdata_d = '0;
        if (hit_sel) begin
            for (int k = 0; k < N_SINK; k++)
                if (off_sel[11:2] == 10'(k)) rdata_d[SELW-1:0] = sel_sh_q[k];
        end else if (hit_mask) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (off_mask[11:2] == 10'(s)) begin
                    rdata_d[N_OUT-1:0] = mask_sh_q[s];
`ifdef DSP_ROUTE_SHIFT_EN
                    rdata_d[SHIFT_LSB +: SHIFT_W] = shift_sh_q[s];
`endif
                end
            end
        end else if (hit_ovf) begin
            for (int o = 0; o < N_OUT; o++)
                if (off_ovf[11:2] == 10'(o)) rdata_d[CNTW-1:0] = ovf_q[o];
        end else if (is_status) begin
            rdata_d[N_OUT-1:0] = sticky_q;
            rdata_d[PEND_BIT]  = pending_q;
        end
    end

    // Shadows take effect only on COMMIT, so every sink and mask flips on one edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N_SINK; k++) begin
                sel_sh_q[k]  <= NONE;
                sel_act_q[k] <= NONE;
            end
            for (int s = 0; s < N_SRC; s++) begin
                mask_sh_q[s]  <= '0;
                mask_act_q[s] <= '0;
`ifdef DSP_ROUTE_SHIFT_EN
                shift_sh_q[s]  <= '0;
                shift_act_q[s] <= '0;
`endif
            end
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack_q   <= sys_wen | sys_ren;
            err_q   <= (sys_wen | sys_ren) & bad;
            rdata_q <= (sys_ren && !sys_wen) ? rdata_d : '0;
            if (sys_wen) begin
                if (hit_sel) begin
                    for (int k = 0; k < N_SINK; k++)
                        if (off_sel[11:2] == 10'(k)) sel_sh_q[k] <= sys_wdata[SELW-1:0];
                    pending_q <= 1'b1;
                end
                if (hit_mask) begin
                    for (int s = 0; s < N_SRC; s++) begin
                        if (off_mask[11:2] == 10'(s)) begin
                            mask_sh_q[s] <= sys_wdata[N_OUT-1:0];
`ifdef DSP_ROUTE_SHIFT_EN
                            shift_sh_q[s] <= sys_wdata[SHIFT_LSB +: SHIFT_W];
`endif
                        end
                    end
                    pending_q <= 1'b1;
                end
                if (is_commit) begin
                    sel_act_q  <= sel_sh_q;
                    mask_act_q <= mask_sh_q;
`ifdef DSP_ROUTE_SHIFT_EN
                    shift_act_q <= shift_sh_q;
`endif
                    pending_q  <= 1'b0;
                end
            end
        end
    end

    // Saturation in the same cycle as a clear wins over the clear.
    always_comb begin
        clr_sticky = (sys_wen && is_status) ? sys_wdata[N_OUT-1:0] : '0;
        sticky_d   = (sticky_q & ~clr_sticky) | out_sat_o;
        for (int o = 0; o < N_OUT; o++) begin
            ovf_d[o] = ovf_q[o];
            if (out_sat_o[o]) begin
                if (sys_wen && hit_ovf && off_ovf[11:2] == 10'(o))
                    ovf_d[o] = CNTW'(1);
                else if (ovf_q[o] != {CNTW{1'b1}})
                    ovf_d[o] = ovf_q[o] + CNTW'(1);
            end else if (sys_wen && hit_ovf && off_ovf[11:2] == 10'(o)) begin
                ovf_d[o] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sticky_q <= '0;
            for (int o = 0; o < N_OUT; o++) ovf_q[o] <= '0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        sink_d = '0;
        for (int k = 0; k < N_SINK; k++)
            for (int s = 0; s < N_SRC; s++)
                if (sel_act_q[k] == SELW'(s)) sink_d[k*DW +: DW] = src_dat_i[s*DW +: DW];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sink_q <= '0;
        else         sink_q <= sink_d;
    end

`ifdef DSP_ROUTE_SHIFT_EN
    always_comb begin
        for (int s = 0; s < N_SRC; s++) shift_flat[s*3 +: 3] = shift_act_q[s];
    end
`endif

    genvar go;
    generate
        for (go = 0; go < N_OUT; go++) begin : g_out
            logic [N_SRC-1:0] chan_mask;
            always_comb begin
                for (int s = 0; s < N_SRC; s++) chan_mask[s] = mask_act_q[s][go];
            end
            dsp_route_addtree #(.N_SRC(N_SRC), .DW(DW), .SELW(SELW)) u_tree (
                .clk_i     (clk_i),
                .rstn_i    (rstn_i),
                .dir_dat_i (dir_dat_i),
                .mask_i    (chan_mask),
`ifdef DSP_ROUTE_SHIFT_EN
                .shift_i   (shift_flat),
`endif
                .sum_o     (out_dat_o[go*DW +: DW]),
                .sat_o     (out_sat_o[go])
            );
        end
    endgenerate

    assign sink_dat_o = sink_q;
    assign sys_rdata  = rdata_q;
    assign sys_ack    = ack_q;
    assign sys_err    = err_q;

endmodule

// File: tb/tb_dsp_route_sum_matrix.sv
// tb/tb_dsp_route_sum_matrix.sv - directed self-checking bench for dsp_route_sum_matrix
module tb_dsp_route_sum_matrix;

    localparam int N_SRC  = 16;
    localparam int N_SINK = 12;
    localparam int N_OUT  = 2;
    localparam int DW     = 14;
    localparam int SELW   = 5;
    localparam int CNTW   = 16;
    localparam logic [31:0] NONE = 32'd31;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [N_SRC*DW-1:0]  src = '0;
    logic [N_SRC*DW-1:0]  dir = '0;
    logic [N_SINK*DW-1:0] sink;
    logic [N_OUT*DW-1:0]  outd;
    logic [N_OUT-1:0]     sat;
    logic [31:0]          sys_addr = '0;
    logic [31:0]          sys_wdata = '0;
    logic                 sys_wen = 1'b0;
    logic                 sys_ren = 1'b0;
    logic [31:0]          sys_rdata;
    logic                 sys_ack;
    logic                 sys_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_route_sum_matrix #(
        .N_SRC(N_SRC), .N_SINK(N_SINK), .N_OUT(N_OUT), .DW(DW), .SELW(SELW), .CNTW(CNTW)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .src_dat_i  (src),
        .dir_dat_i  (dir),
        .sink_dat_o (sink),
        .out_dat_o  (outd),
        .out_sat_o  (sat),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_ack    (sys_ack),
        .sys_err    (sys_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the ack is visible.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        check("wr_ack", {31'd0, sys_ack}, 32'd1);
        e = sys_err;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        sys_addr = a;
        sys_ren  = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        check("rd_ack", {31'd0, sys_ack}, 32'd1);
        d = sys_rdata;
        e = sys_err;
    endtask

    function automatic logic [31:0] sk(input logic [N_SINK*DW-1:0] v, input int k);
        return 32'(v[k*DW +: DW]);
    endfunction

    function automatic logic [31:0] od(input logic [N_OUT*DW-1:0] v, input int o);
        return 32'(v[o*DW +: DW]);
    endfunction

    initial begin
        logic [31:0] rd, c1, c2;
        logic        e;

        repeat (3) @(negedge clk);
        check("rst_sink", 32'(sink), 32'd0);
        check("rst_out", 32'(outd), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        bus_rd(32'h000, rd, e);
        check("sel0_none", rd, NONE);
        check("sel0_err", {31'd0, e}, 32'd0);

        src[3*DW +: DW] = 14'h0123;
        bus_wr(32'h000, 32'd3, e);
        repeat (2) @(negedge clk);
        check("sink0_precommit", sk(sink, 0), 32'd0);
        bus_rd(32'h204, rd, e);
        check("pending_set", rd, 32'h0001_0000);
        bus_wr(32'h200, 32'd0, e);
        check("sink0_at_ack", sk(sink, 0), 32'd0);
        @(negedge clk);
        check("sink0_routed", sk(sink, 0), 32'h0123);
        bus_rd(32'h204, rd, e);
        check("pending_clr", rd, 32'd0);

        // Sum of two positive sources into channel 0 only.
        dir[0*DW +: DW] = 14'h1000;
        dir[1*DW +: DW] = 14'h0800;
        bus_wr(32'h100, 32'b01, e);
        bus_wr(32'h104, 32'b01, e);
        bus_wr(32'h200, 32'd0, e);
        repeat (4) @(negedge clk);
        check("sum_before_L", od(outd, 0), 32'd0);
        @(negedge clk);
        check("sum_at_L", od(outd, 0), 32'h1800);
        check("sum_ch1", od(outd, 1), 32'd0);
        check("sum_nosat", 32'(sat), 32'd0);
        bus_rd(32'h204, rd, e);
        check("status_clean", rd, 32'd0);

        // Positive saturation on both channels.
        dir[0*DW +: DW] = 14'h1FFF;
        dir[1*DW +: DW] = 14'h1FFF;
        bus_wr(32'h100, 32'b11, e);
        bus_wr(32'h104, 32'b11, e);
        bus_wr(32'h200, 32'd0, e);
        repeat (6) @(negedge clk);
        check("psat_ch0", od(outd, 0), 32'h1FFF);
        check("psat_ch1", od(outd, 1), 32'h1FFF);
        check("psat_flag", 32'(sat), 32'd3);
        bus_rd(32'h204, rd, e);
        check("sticky_set", rd, 32'd3);
        bus_rd(32'h208, c1, e);
        bus_rd(32'h208, c2, e);
        check("ovf_nonzero", {31'd0, c1 != 0}, 32'd1);
        check("ovf_step", c2, c1 + 32'd1);

        bus_wr(32'h204, 32'd3, e);
        bus_rd(32'h204, rd, e);
        check("sticky_clr_vs_sat", rd, 32'd3);
        bus_wr(32'h208, 32'd0, e);
        check("ovf_wr_err", {31'd0, e}, 32'd0);
        bus_rd(32'h208, rd, e);
        check("ovf_clr_vs_sat", rd, 32'd1);

        // Negative saturation.
        dir[0*DW +: DW] = 14'h2000;
        dir[1*DW +: DW] = 14'h2000;
        repeat (6) @(negedge clk);
        check("nsat_ch0", od(outd, 0), 32'h2000);
        check("nsat_ch1", od(outd, 1), 32'h2000);
        check("nsat_flag", 32'(sat), 32'd3);

        dir = '0;
        repeat (6) @(negedge clk);
        check("idle_flag", 32'(sat), 32'd0);
        check("idle_out", 32'(outd), 32'd0);
        bus_wr(32'h204, 32'd3, e);
        bus_rd(32'h204, rd, e);
        check("sticky_cleared", rd, 32'd0);
        bus_wr(32'h208, 32'd0, e);
        bus_wr(32'h20C, 32'd0, e);
        repeat (3) @(negedge clk);
        bus_rd(32'h208, rd, e);
        check("ovf0_cleared", rd, 32'd0);
        bus_rd(32'h20C, rd, e);
        check("ovf1_cleared", rd, 32'd0);

        // Bus errors.
        bus_rd(32'hFFC, rd, e);
        check("err_rd_ffc", {31'd0, e}, 32'd1);
        bus_wr(32'h140, 32'd1, e);
        check("err_wr_140", {31'd0, e}, 32'd1);
        bus_rd(32'h210, rd, e);
        check("err_rd_210", {31'd0, e}, 32'd1);
        bus_rd(32'h204, rd, e);
        check("err_no_pending", rd, 32'd0);

        // Routing to the last sink and to a NONE code that is not all-ones.
        src[15*DW +: DW] = 14'h2ABC;
        bus_wr(32'h02C, 32'd15, e);
        bus_wr(32'h004, 32'd3, e);
        bus_wr(32'h200, 32'd0, e);
        @(negedge clk);
        check("sink11", sk(sink, 11), 32'h2ABC);
        check("sink1", sk(sink, 1), 32'h0123);
        bus_wr(32'h004, 32'd20, e);
        bus_rd(32'h004, rd, e);
        check("sel1_rd", rd, 32'd20);
        bus_wr(32'h200, 32'd0, e);
        @(negedge clk);
        check("sink1_none", sk(sink, 1), 32'd0);

        bus_wr(32'h100, 32'd0, e);
        bus_wr(32'h104, 32'd0, e);
        bus_wr(32'h108, 32'h201, e);
        bus_rd(32'h108, rd, e);
        dir[2*DW +: DW] = 14'h0400;
        bus_wr(32'h200, 32'd0, e);
        repeat (6) @(negedge clk);
`ifdef DSP_ROUTE_SHIFT_EN
        check("shift_rd", rd, 32'h201);
        check("shift_pos", od(outd, 0), 32'h0100);
        check("shift_ch1", od(outd, 1), 32'd0);
        dir[2*DW +: DW] = 14'h3000;
        repeat (6) @(negedge clk);
        check("shift_neg", od(outd, 0), 32'h3C00);
`else
        check("noshift_rd", rd, 32'h001);
        check("noshift_out", od(outd, 0), 32'h0400);
        check("noshift_ch1", od(outd, 1), 32'd0);
`endif

        rstn = 1'b0;
        #1;
        check("midrst_out", 32'(outd), 32'd0);
        check("midrst_sink", sk(sink, 11), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus_rd(32'h02C, rd, e);
        check("midrst_sel", rd, NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
